// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the handshaked pipeline stage register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the stage state encoding, default widths and the payload width of
// every MIPS32 inter-stage boundary that instantiates pipe_stage_reg.
package pipe_stage_pkg;

    // SKID is only reachable when the two-entry build (PIPE_SKID_EN) is used.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_CNT_W  = 16;

    // IF/ID : {PC_Plus_4[31:0], Instruction[31:0]}
    localparam int IFID_W  = 64;
    // ID/EX : PC+4, rs data, rt data, sign-extended imm (4x32), rt/rd (2x5), 9 control bits
    localparam int IDEX_W  = 147;
    // EX/MEM: branch target, zero flag, ALU result, rt data, dest reg, 5 control bits
    localparam int EXMEM_W = 107;
    // MEM/WB: read data, ALU result, dest reg, 2 control bits
    localparam int MEMWB_W = 71;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload bus between two pipeline stages.
// Latency: n/a (wiring only).
// Backpressure: Ready from the receiver gates the transfer.
//
// Signals: Valid (sender holds payload), Data (payload), Ready (receiver accepts).
// master = sending side, slave = receiving side.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              Valid;
    logic [DATA_W-1:0] Data;
    logic              Ready;

    modport master (output Valid, output Data, input  Ready);
    modport slave  (input  Valid, input  Data, output Ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for stall and other performance counters.
// Latency: count updates on the rising edge after Inc.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports: Clk, Reset (async, active-high), Inc (count this cycle), Count.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Inc,
    output logic [CNT_W-1:0] Count
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
        end else if (Inc && (Count != '1)) begin
            Count <= Count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline register with flush, stall hold and stall-cycle counter.
// Latency: 1 cycle from accept to Out_Data; 1 entry/cycle with Out_Ready=1, Stall=0.
// Backpressure: In_Ready drops on Stall, Flush or a full stage; Stall freezes all transfers.
//
// Ports: Clk, Reset (async, active-high); In_Bus (slave: In_Valid/In_Data/In_Ready);
// Out_Bus (master: Out_Valid/Out_Data/Out_Ready); Stall, Flush; Occupancy (0..2);
// Stall_Cycles (saturating).
// Build option PIPE_SKID_EN: adds a skid entry so In_Ready never depends on Out_Ready.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter int                CNT_W      = DEF_CNT_W
) (
    input  logic                   Clk,
    input  logic                   Reset,
    pipe_stage_reg_if.slave        In_Bus,
    pipe_stage_reg_if.master       Out_Bus,
    input  logic                   Stall,
    input  logic                   Flush,
    output logic [1:0]             Occupancy,
    output logic [CNT_W-1:0]       Stall_Cycles
);

    stage_state_e      state;
    logic [DATA_W-1:0] main_data;
    logic              out_vld;
    logic [1:0]        occ;
    logic              in_rdy;
    logic              acc;
    logic              rel;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data;

    // Ready is a function of registered state only, so the upstream timing
    // path never reaches through to the downstream Ready.
    assign in_rdy = !Stall && !Flush && (state != SKID);
`else
    // Single entry: can only take a new word if the current one leaves now.
    assign in_rdy = !Stall && !Flush && (!out_vld || Out_Bus.Ready);
`endif

    assign acc = In_Bus.Valid && in_rdy;
    assign rel = out_vld && Out_Bus.Ready && !Stall;

    assign In_Bus.Ready  = in_rdy;
    assign Out_Bus.Valid = out_vld;
    assign Out_Bus.Data  = main_data;
    assign Occupancy     = occ;

    // Occupancy/valid are kept as registers alongside the state so the
    // outputs come straight from flops.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= EMPTY;
            main_data <= RESET_DATA;
            out_vld   <= 1'b0;
            occ       <= 2'd0;
`ifdef PIPE_SKID_EN
            skid_data <= RESET_DATA;
`endif
        end else if (Flush) begin
            // Squash: drop every held entry; payload registers keep stale data.
            state   <= EMPTY;
            out_vld <= 1'b0;
            occ     <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_data <= In_Bus.Data;
                        state     <= FULL;
                        out_vld   <= 1'b1;
                        occ       <= 2'd1;
                    end
                end
                FULL: begin
                    if (acc && rel) begin
                        // Pass-through: old word leaves, new word takes its place.
                        main_data <= In_Bus.Data;
                    end else if (rel) begin
                        state   <= EMPTY;
                        out_vld <= 1'b0;
                        occ     <= 2'd0;
                    end
`ifdef PIPE_SKID_EN
                    else if (acc) begin
                        // Older word stays in main so ordering is preserved.
                        skid_data <= In_Bus.Data;
                        state     <= SKID;
                        occ       <= 2'd2;
                    end
`endif
                end
`ifdef PIPE_SKID_EN
                SKID: begin
                    if (rel) begin
                        main_data <= skid_data;
                        state     <= FULL;
                        occ       <= 2'd1;
                    end
                end
`endif
                default: begin
                    state   <= EMPTY;
                    out_vld <= 1'b0;
                    occ     <= 2'd0;
                end
            endcase
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (Stall || (out_vld && !Out_Bus.Ready)),
        .Count (Stall_Cycles)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic [1:0]  occ16;
    logic [15:0] cnt16;
    logic [1:0]  occ4;
    logic [3:0]  cnt4;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg_if #(.DATA_W(64)) in_b ();
    pipe_stage_reg_if #(.DATA_W(64)) out_b ();
    pipe_stage_reg_if #(.DATA_W(64)) in_b4 ();
    pipe_stage_reg_if #(.DATA_W(64)) out_b4 ();

    // Second instance with a 4-bit counter shares all stimulus.
    assign in_b4.Valid  = in_b.Valid;
    assign in_b4.Data   = in_b.Data;
    assign out_b4.Ready = out_b.Ready;

    pipe_stage_reg #(.DATA_W(64), .RESET_DATA(64'h0), .CNT_W(16)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .In_Bus       (in_b),
        .Out_Bus      (out_b),
        .Stall        (Stall),
        .Flush        (Flush),
        .Occupancy    (occ16),
        .Stall_Cycles (cnt16)
    );

    pipe_stage_reg #(.DATA_W(64), .RESET_DATA(64'h0), .CNT_W(4)) dut4 (
        .Clk          (Clk),
        .Reset        (Reset),
        .In_Bus       (in_b4),
        .Out_Bus      (out_b4),
        .Stall        (Stall),
        .Flush        (Flush),
        .Occupancy    (occ4),
        .Stall_Cycles (cnt4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [63:0] id, input logic ordy,
                         input logic st, input logic fl);
        in_b.Valid  = iv;
        in_b.Data   = id;
        out_b.Ready = ordy;
        Stall       = st;
        Flush       = fl;
    endtask

    // Reference: an ordered queue with capacity 1 (plain) or 2 (skid build).
    function automatic logic m_rdy(int sz, logic st, logic fl, logic ordy);
`ifdef PIPE_SKID_EN
        return !st && !fl && (sz < 2);
`else
        return !st && !fl && ((sz == 0) || ordy);
`endif
    endfunction

    typedef struct {
        logic        iv;
        logic [63:0] id;
        logic        ordy;
        logic        st;
        logic        fl;
        logic        e_irdy;
        logic        e_ov;
        logic [63:0] e_od;
        logic [1:0]  e_occ;
        int          e_cnt;
    } vec_t;

    vec_t tbl[13];

    logic [63:0] q[$];
    int          m16;
    int          m4;

    initial begin
        // iv, id, ordy, st, fl | in_rdy, out_vld, out_dat, occ, stall_cycles
        tbl[0]  = '{1'b1, 64'h1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1,  2'd1, 0};
        tbl[1]  = '{1'b1, 64'h2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h2,  2'd1, 0};
        tbl[2]  = '{1'b1, 64'h3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h3,  2'd1, 0};
        tbl[3]  = '{1'b1, 64'h4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h4,  2'd1, 0};
        tbl[4]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  2'd0, 0};
        tbl[5]  = '{1'b1, 64'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hA5, 2'd1, 0};
        tbl[6]  = '{1'b1, 64'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA5, 2'd1, 1};
        tbl[7]  = '{1'b1, 64'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA5, 2'd1, 2};
        tbl[8]  = '{1'b1, 64'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA5, 2'd1, 3};
        tbl[9]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  2'd0, 3};
        tbl[10] = '{1'b1, 64'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h10, 2'd1, 3};
        tbl[11] = '{1'b1, 64'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  2'd0, 3};
        tbl[12] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  2'd0, 3};

        // ---------------- reset state ----------------
        Reset = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_out_vld", out_b.Valid, 1'b0);
        chk("rst_out_dat", out_b.Data, 64'h0);
        chk("rst_occ", occ16, 2'd0);
        chk("rst_cnt", cnt16, 16'd0);
        chk("rst_in_rdy", in_b.Ready, 1'b1);
        Reset = 1'b0;

        // ---------------- table: streaming, stall, flush ----------------
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].st, tbl[i].fl);
            @(negedge Clk);
            chk($sformatf("tbl%0d_in_rdy", i), in_b.Ready, tbl[i].e_irdy);
            tick();
            chk($sformatf("tbl%0d_out_vld", i), out_b.Valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_occ", i), occ16, tbl[i].e_occ);
            chk($sformatf("tbl%0d_cnt", i), cnt16, 64'(tbl[i].e_cnt));
            if (tbl[i].e_ov)
                chk($sformatf("tbl%0d_out_dat", i), out_b.Data, tbl[i].e_od);
        end

        // ---------------- backpressure ----------------
        drive(1'b1, 64'hA1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hA2, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
        @(negedge Clk);
        chk("bp_second_rdy", in_b.Ready, 1'b1);
        tick();
        chk("bp_occ2", occ16, 2'd2);
        chk("bp_full_rdy", in_b.Ready, 1'b0);
        chk("bp_head_a1", out_b.Data, 64'hA1);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_rel1_dat", out_b.Data, 64'hA2);
        chk("bp_rel1_occ", occ16, 2'd1);
        tick();
        chk("bp_rel2_vld", out_b.Valid, 1'b0);
`else
        @(negedge Clk);
        chk("bp_blocked_rdy", in_b.Ready, 1'b0);
        tick();
        chk("bp_hold_occ", occ16, 2'd1);
        chk("bp_hold_dat", out_b.Data, 64'hA1);
        drive(1'b1, 64'hA2, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        chk("bp_pass_rdy", in_b.Ready, 1'b1);
        tick();
        chk("bp_pass_dat", out_b.Data, 64'hA2);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_rel_vld", out_b.Valid, 1'b0);
`endif

        // ---------------- flush with stage full ----------------
        drive(1'b1, 64'hB1, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef PIPE_SKID_EN
        drive(1'b1, 64'hB2, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fl_pre_occ", occ16, 2'd2);
`else
        chk("fl_pre_occ", occ16, 2'd1);
`endif
        drive(1'b1, 64'hBAD, 1'b1, 1'b1, 1'b1);
        tick();
        chk("fl_vld", out_b.Valid, 1'b0);
        chk("fl_occ", occ16, 2'd0);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl_lost%0d", i), out_b.Valid, 1'b0);
        end

        // ---------------- saturation (CNT_W=4 vs 16) ----------------
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        drive(1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) chk("sat_cnt4_at15", cnt4, 4'd15);
        end
        chk("sat_cnt4_stop", cnt4, 4'd15);
        chk("sat_cnt16", cnt16, 16'd20);

        // ---------------- async reset mid-cycle ----------------
        #3;
        Reset = 1'b1;
        #1;
        chk("arst_vld", out_b.Valid, 1'b0);
        chk("arst_dat", out_b.Data, 64'h0);
        chk("arst_cnt", cnt16, 16'd0);
        chk("arst_occ", occ16, 2'd0);
        tick();
        Reset = 1'b0;

        // ---------------- random vs queue model ----------------
        q.delete();
        m16 = 0;
        m4  = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        iv, ordy, st, fl, mr;
            logic [63:0] id;
            iv   = ($urandom_range(3) != 0);
            ordy = ($urandom_range(2) != 0);
            st   = ($urandom_range(4) == 0);
            fl   = ($urandom_range(15) == 0);
            id   = {$urandom, $urandom};
            drive(iv, id, ordy, st, fl);
            mr = m_rdy(q.size(), st, fl, ordy);
            @(negedge Clk);
            chk($sformatf("rnd%0d_in_rdy", cyc), in_b.Ready, mr);
            chk($sformatf("rnd%0d_out_vld", cyc), out_b.Valid, q.size() > 0);
            chk($sformatf("rnd%0d_occ", cyc), occ16, 64'(q.size()));
            chk($sformatf("rnd%0d_cnt16", cyc), cnt16, 64'(m16));
            chk($sformatf("rnd%0d_cnt4", cyc), cnt4, 64'(m4));
            if (q.size() > 0)
                chk($sformatf("rnd%0d_out_dat", cyc), out_b.Data, q[0]);
            @(posedge Clk);
            if (st || ((q.size() > 0) && !ordy)) begin
                if (m16 < 65535) m16++;
                if (m4 < 15) m4++;
            end
            if (fl) begin
                q.delete();
            end else begin
                if ((q.size() > 0) && ordy && !st) void'(q.pop_front());
                if (iv && mr) q.push_back(id);
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised handshaked pipeline register, the successor of the fixed 32-bit IF/ID stage register. It adds valid/ready flow control, flush, stall hold, a stall-cycle performance counter and an optional skid entry. Every inter-stage boundary of the MIPS32 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it, with the stage payload packed into one bus.

## Interface
- DATA_W, 64, payload width; IF/ID uses {PC_Plus_4, Instruction}.
- RESET_DATA, 0, value driven on Out_Data after reset; all-zero is the MIPS NOP.
- CNT_W, 16, width of the stall-cycle counter.
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- In_Valid  in  1  upstream holds valid payload.
- In_Data  in  DATA_W  upstream payload.
- In_Ready  out  1  stage accepts In_Data this cycle.
- Out_Valid  out  1  stage holds a valid entry.
- Out_Data  out  DATA_W  oldest held entry.
- Out_Ready  in  1  downstream accepts this cycle.
- Stall  in  1  hazard hold: no accept, no release.
- Flush  in  1  branch/jump squash: discard all held entries.
- Occupancy  out  2  number of held entries: 0, 1 or 2.
- Stall_Cycles  out  CNT_W  saturating count of blocked cycles.

## Operation
- Accept = In_Valid & In_Ready. Release = Out_Valid & Out_Ready & !Stall.
- States: EMPTY, FULL, and SKID (SKID exists only with PIPE_SKID_EN).
- EMPTY→FULL on accept.
- FULL→EMPTY on release without accept.
- FULL→FULL on release with accept (pass-through), or on no release and no accept.
- FULL→SKID on accept without release. The new entry goes into the skid register; the main register keeps the older entry.
- SKID→FULL on release: the skid entry moves to main.
- In_Ready:
  - without skid: !Stall & !Flush & (!Out_Valid | Out_Ready).
  - with skid: !Stall & !Flush & (state != SKID). It depends only on registered state and the two control inputs, never on Out_Ready.
- Flush takes priority over all other events. The next state is EMPTY, and a same-cycle accept or release is ignored. Data registers are not cleared; only the valid bits are.
- Stall holds state and data unchanged. Out_Valid and Out_Data stay visible, but no transfer takes place.
- Stall_Cycles increments by 1 in every cycle where Stall=1, or where Out_Valid=1 and Out_Ready=0. It saturates at 2^CNT_W−1 and is cleared only by Reset.
- Entries leave in strict FIFO order.

## Timing
- Reset values:
  - Out_Valid=0, Occupancy=0, Stall_Cycles=0.
  - Out_Data=RESET_DATA, skid data=RESET_DATA, state=EMPTY.
  - In_Ready follows its combinational formula.
- Latency is 1 cycle: data accepted at edge N appears on Out_Data after edge N.
- Throughput is 1 entry per cycle while Out_Ready=1 and Stall=0.
- Flush asserted in cycle N gives Out_Valid=0 after edge N. An In_Valid present in cycle N is lost; the upstream must also squash.
- When Stall and Flush are both high, Flush wins.
- Reset asserted mid-transfer forces reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.
- Occupancy=2 occurs only in SKID.

## Configuration
- PIPE_SKID_EN defined:
  - two-entry stage with the SKID state.
  - In_Ready is free of any combinational path from Out_Ready.
  - full throughput when Out_Ready is registered downstream.
- PIPE_SKID_EN undefined:
  - single register; the SKID state and skid data register are not built.
  - Occupancy never exceeds 1.
  - In_Ready has a combinational path from Out_Ready.

## Structure
- Package pipe_stage_pkg holds:
  - the state enum {EMPTY, FULL, SKID}.
  - default DATA_W/CNT_W constants.
  - per-boundary payload width constants: IFID_W=64, IDEX_W, EXMEM_W, MEMWB_W.
- One sub-module, pipe_sat_counter: parametrised by CNT_W, with inputs Clk, Reset and Inc, and a saturating output. It implements Stall_Cycles and is reused elsewhere for other performance counters.

## Test plan
- Reset: drive Reset=1 mid-cycle with RESET_DATA=0 → Out_Valid=0, Out_Data=0x0, Stall_Cycles=0 at once, without waiting for an edge.
- Streaming: drive 4 words 0x…01 to 0x…04 with Out_Ready=1 → each word appears one cycle after it is accepted, In_Ready stays 1 throughout, and Occupancy stays 1.
- Backpressure (skid build only):
  - Out_Ready=0 with 2 words offered → both accepted, Occupancy=2, In_Ready=0.
  - Out_Ready=1 for 2 cycles → the words are released in order.
- Stall: Stall=1 for 3 cycles with FULL holding 0xA5 → Out_Data holds 0xA5, no accept occurs, and Stall_Cycles increases by 3.
- Flush: Flush=1 in the same cycle as In_Valid=1 with Occupancy=2 → Out_Valid=0, Occupancy=0 next cycle, and the offered word is never output.
- Saturation: CNT_W=4, Out_Ready=0 for 20 cycles → Stall_Cycles stops at 15.
